// File: rtl/llr_pkg.sv
// Shared types and helpers for the LLR input stage of the min-sum decoder.
package llr_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    FULL = 2'd1,
    DROP = 2'd2
  } llr_state_e;

  // Largest magnitude a WIDTH-bit LLR may take; the most negative code stays unused.
  function automatic int llr_max_q(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  function automatic int llr_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/llr_quantizer.sv
// Channel LLR quantizer: arithmetic right shift, then symmetric saturation to WIDTH bits.
module llr_quantizer
  import llr_pkg::*;
#(
  parameter int IN_WIDTH  = 12,
  parameter int WIDTH     = 8,
  parameter int FRAC_DROP = 2
) (
  input  logic signed [IN_WIDTH-1:0] in_llr,
  output logic signed [WIDTH-1:0]    q_llr,
  output logic                       clip
);

  localparam int MAX_Q = llr_max_q(WIDTH);
  localparam logic signed [IN_WIDTH-1:0] MAX_I = IN_WIDTH'(MAX_Q);
  localparam logic signed [IN_WIDTH-1:0] MIN_I = -MAX_I;
  localparam logic signed [WIDTH-1:0]    MAX_O = WIDTH'(MAX_Q);
  localparam logic signed [WIDTH-1:0]    MIN_O = -MAX_O;

  logic signed [IN_WIDTH-1:0] shifted;

  assign shifted = in_llr >>> FRAC_DROP;

  always_comb begin
    q_llr = shifted[WIDTH-1:0];
    clip  = 1'b0;
    if (shifted > MAX_I) begin
      q_llr = MAX_O;
      clip  = 1'b1;
    end else if (shifted < MIN_I) begin
      q_llr = MIN_O;
      clip  = 1'b1;
    end
  end

endmodule

// File: rtl/llr_frame_loader.sv
// Double-buffered frame loader: quantizes streamed LLRs into a shadow frame and hands
// complete frames to the decoder. Optional LLR_SAT_COUNT_EN adds a clipped-beat counter.
module llr_frame_loader
  import llr_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int N_V       = 44,
  parameter int IN_WIDTH  = 12,
  parameter int FRAC_DROP = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [IN_WIDTH-1:0] in_llr,
  input  logic                       in_last,
  output logic                       in_ready,
  input  logic                       data_ack,
  output logic [WIDTH*N_V-1:0]       all_llrs,
  output logic                       data_ready,
  output logic                       frame_err
`ifdef LLR_SAT_COUNT_EN
  ,
  output logic [15:0]                sat_count
`endif
);

  localparam int CNT_W = (N_V > 1) ? $clog2(N_V) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_V - 1);

  llr_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH*N_V-1:0] shadow_q, shadow_d;
  logic [WIDTH*N_V-1:0] all_llrs_q, all_llrs_d;
  logic                 data_ready_q, data_ready_d;
  logic                 frame_err_q, frame_err_d;

  logic signed [WIDTH-1:0] q_llr;
  logic                    q_clip;
  logic                    accept;
  logic                    buf_free;
  logic                    xfer;

  llr_quantizer #(
    .IN_WIDTH (IN_WIDTH),
    .WIDTH    (WIDTH),
    .FRAC_DROP(FRAC_DROP)
  ) u_quant (
    .in_llr(in_llr),
    .q_llr (q_llr),
    .clip  (q_clip)
  );

  assign in_ready = !rst && (state_q != FULL);
  assign accept   = in_valid && in_ready;
  // An acknowledge in the same cycle frees the output buffer for an immediate transfer.
  assign buf_free = !data_ready_q || data_ack;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    all_llrs_d   = all_llrs_q;
    frame_err_d  = 1'b0;
    xfer         = 1'b0;
    case (state_q)
      FILL: begin
        if (accept) begin
          shadow_d[llr_lsb(int'(cnt_q), WIDTH) +: WIDTH] = q_llr;
          if (cnt_q == LAST_IDX) begin
            cnt_d = '0;
            if (in_last) begin
              if (buf_free) begin
                all_llrs_d = shadow_d;
                xfer       = 1'b1;
              end else begin
                state_d = FULL;
              end
            end else begin
              frame_err_d = 1'b1;
              state_d     = DROP;
            end
          end else if (in_last) begin
            frame_err_d = 1'b1;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FULL: begin
        if (buf_free) begin
          all_llrs_d = shadow_q;
          xfer       = 1'b1;
          state_d    = FILL;
        end
      end
      DROP: begin
        if (accept && in_last) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
    data_ready_d = data_ready_q;
    if (xfer) data_ready_d = 1'b1;
    else if (data_ack) data_ready_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      shadow_q     <= '0;
      all_llrs_q   <= '0;
      data_ready_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      all_llrs_q   <= all_llrs_d;
      data_ready_q <= data_ready_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign all_llrs   = all_llrs_q;
  assign data_ready = data_ready_q;
  assign frame_err  = frame_err_q;

`ifdef LLR_SAT_COUNT_EN
  logic [15:0] sat_count_q, sat_count_d;

  // Counts every accepted clipped beat, including dropped and erroneous frames.
  always_comb begin
    sat_count_d = sat_count_q;
    if (accept && q_clip && (sat_count_q != 16'hFFFF)) sat_count_d = sat_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) sat_count_q <= '0;
    else     sat_count_q <= sat_count_d;
  end

  assign sat_count = sat_count_q;
`else
  logic sat_unused;
  assign sat_unused = q_clip;
`endif

endmodule

// File: tb/tb_llr_frame_loader.sv
// Self-checking bench for llr_frame_loader: frame-level reference model compared every
// cycle, plus literal slot/flag checks. Define LLR_SAT_COUNT_EN to also check sat_count.
module tb_llr_frame_loader;

  localparam int W  = 8;
  localparam int NV = 44;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic signed [11:0] in_llr;
  logic              in_last;
  logic              in_ready;
  logic              data_ack;
  logic [W*NV-1:0]   all_llrs;
  logic              data_ready;
  logic              frame_err;
`ifdef LLR_SAT_COUNT_EN
  logic [15:0]       sat_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  llr_frame_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_llr    (in_llr),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .data_ack  (data_ack),
    .all_llrs  (all_llrs),
    .data_ready(data_ready),
    .frame_err (frame_err)
`ifdef LLR_SAT_COUNT_EN
    ,
    .sat_count (sat_count)
`endif
  );

  // Frame-level reference model: current partial frame, one pending frame, one output frame.
  bit         m_live = 1'b0;
  bit         m_rdy, m_err, m_pend, m_drop;
  logic [7:0] m_out[NV];
  logic [7:0] m_pbuf[NV];
  logic [7:0] m_cur[NV];
  int         m_len;
  int         m_sat;

  function automatic int shifted(input int v);
    return v >>> 2;
  endfunction

  function automatic bit clips(input int v);
    return (shifted(v) > 127) || (shifted(v) < -127);
  endfunction

  function automatic logic [7:0] quant(input int v);
    int s;
    s = shifted(v);
    if (s > 127) s = 127;
    else if (s < -127) s = -127;
    return 8'(s);
  endfunction

  function automatic logic [W*NV-1:0] model_bus();
    logic [W*NV-1:0] b;
    for (int i = 0; i < NV; i++) b[i*W +: W] = m_out[i];
    return b;
  endfunction

  always @(posedge clk) begin : model_p
    int v;
    bit free, xfer;
    if (rst) begin
      m_live = 1'b1;
      m_rdy  = 1'b0;
      m_err  = 1'b0;
      m_pend = 1'b0;
      m_drop = 1'b0;
      m_len  = 0;
      m_sat  = 0;
      for (int i = 0; i < NV; i++) m_out[i] = 8'h00;
    end else if (m_live) begin
      v     = in_llr;
      free  = !m_rdy || data_ack;
      xfer  = 1'b0;
      m_err = 1'b0;
      if (!m_pend && in_valid && clips(v) && m_sat < 65535) m_sat++;
      if (m_pend) begin
        if (free) begin
          m_out  = m_pbuf;
          xfer   = 1'b1;
          m_pend = 1'b0;
        end
      end else if (in_valid) begin
        if (m_drop) begin
          if (in_last) m_drop = 1'b0;
        end else begin
          m_cur[m_len] = quant(v);
          m_len++;
          if (m_len == NV) begin
            m_len = 0;
            if (in_last) begin
              if (free) begin
                m_out = m_cur;
                xfer  = 1'b1;
              end else begin
                m_pbuf = m_cur;
                m_pend = 1'b1;
              end
            end else begin
              m_err  = 1'b1;
              m_drop = 1'b1;
            end
          end else if (in_last) begin
            m_err = 1'b1;
            m_len = 0;
          end
        end
      end
      if (xfer) m_rdy = 1'b1;
      else if (data_ack) m_rdy = 1'b0;
    end
  end

  task automatic checkOutput(input string nm, input logic [W*NV-1:0] act,
                             input logic [W*NV-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, shortly after each edge.
  always @(posedge clk) begin
    #1;
    if (m_live) begin
      checkOutput("all_llrs", all_llrs, model_bus());
      checkOutput("data_ready", W*NV'(data_ready), W*NV'(m_rdy));
      checkOutput("frame_err", W*NV'(frame_err), W*NV'(m_err));
      checkOutput("in_ready", W*NV'(in_ready), W*NV'(!rst && !m_pend));
`ifdef LLR_SAT_COUNT_EN
      checkOutput("sat_count", W*NV'(sat_count), W*NV'(m_sat));
`endif
    end
  end

  task automatic applyStimulus(input int v, input bit last);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_llr   = 12'(v);
      in_last  = last;
      #1;
      ok = in_ready;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL beat_timeout: in_ready stayed %b, expected 1", in_ready);
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic sendFrame(input int v);
    for (int i = 0; i < NV; i++) applyStimulus(v, i == NV - 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic ackPulse();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
  endtask

  function automatic logic [W*NV-1:0] slot(input int i);
    return W*NV'(all_llrs[i*W +: W]);
  endfunction

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_llr = '0; in_last = 1'b0; data_ack = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_data_ready", W*NV'(data_ready), '0);
    checkOutput("rst_in_ready", W*NV'(in_ready), '0);
    checkOutput("rst_all_llrs", all_llrs, '0);
    rst = 1'b0;

    // Uniform frame, held until acknowledged.
    sendFrame(40);
    idle(1);
    checkOutput("a_slot0", slot(0), W*NV'(8'h0a));
    checkOutput("a_slot43", slot(43), W*NV'(8'h0a));
    checkOutput("a_ready", W*NV'(data_ready), W*NV'(1));
    idle(5);
    checkOutput("a_held", W*NV'(data_ready), W*NV'(1));
    ackPulse();
    checkOutput("a_acked", W*NV'(data_ready), '0);

    // Saturation at both extremes.
    for (int i = 0; i < NV; i++)
      applyStimulus((i == 0) ? 2047 : (i == 1) ? -2048 : 40, i == NV - 1);
    idle(1);
    checkOutput("sat_pos", slot(0), W*NV'(8'h7f));
    checkOutput("sat_neg", slot(1), W*NV'(8'h81));
    checkOutput("sat_mid", slot(2), W*NV'(8'h0a));
`ifdef LLR_SAT_COUNT_EN
    checkOutput("sat_cnt2", W*NV'(sat_count), W*NV'(2));
`endif
    ackPulse();

    // Short frame, then a ramp frame 0..43.
    for (int i = 0; i < 10; i++) applyStimulus(4, i == 9);
    idle(1);
    checkOutput("short_err", W*NV'(frame_err), W*NV'(1));
    checkOutput("short_noready", W*NV'(data_ready), '0);
    for (int i = 0; i < NV; i++) applyStimulus(4 * i, i == NV - 1);
    idle(1);
    checkOutput("ramp_slot5", slot(5), W*NV'(8'h05));
    checkOutput("ramp_slot43", slot(43), W*NV'(8'h2b));
    ackPulse();

    // Long frame of 45 beats, then a negative ramp.
    for (int i = 0; i < 45; i++) applyStimulus(8, i == 44);
    idle(1);
    checkOutput("long_noready", W*NV'(data_ready), '0);
    for (int i = 0; i < NV; i++) applyStimulus(-4 * i, i == NV - 1);
    idle(1);
    checkOutput("neg_slot10", slot(10), W*NV'(8'hf6));
    checkOutput("neg_ready", W*NV'(data_ready), W*NV'(1));
    ackPulse();

    // Back-to-back frames with acknowledge withheld.
    sendFrame(8);
    sendFrame(12);
    idle(1);
    checkOutput("b2b_full", W*NV'(in_ready), '0);
    checkOutput("b2b_first", slot(0), W*NV'(8'h02));
    ackPulse();
    checkOutput("b2b_second", slot(0), W*NV'(8'h03));
    checkOutput("b2b_ready", W*NV'(data_ready), W*NV'(1));
    checkOutput("b2b_inready", W*NV'(in_ready), W*NV'(1));
    ackPulse();

    // Reset in the middle of a frame while a frame is held.
    sendFrame(40);
    for (int i = 0; i < 19; i++) applyStimulus(16, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_ready", W*NV'(data_ready), '0);
    checkOutput("mid_rst_llrs", all_llrs, '0);
    rst = 1'b0;
    sendFrame(20);
    idle(1);
    checkOutput("post_rst_slot0", slot(0), W*NV'(8'h05));
    checkOutput("post_rst_ready", W*NV'(data_ready), W*NV'(1));
    ackPulse();
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
